// File: rtl/matrix_keypad_scanner_if.sv
// Keypad-side bundle: row drive, column sense and the decoded key outputs.
// master = keypad/consumer side, slave = the scanner.
interface matrix_keypad_scanner_if;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      output col_n,
      input  row_n,
      input  key_code,
      input  key_valid,
      input  key_held
   );

   modport slave (
      input  col_n,
      output row_n,
      output key_code,
      output key_valid,
      output key_held
   );
endinterface

// File: rtl/matrix_keypad_scanner.sv
// 4x4 active-low keypad scanner: one-cold row drive and frame-level classification.
// Press and release are each debounced over DEB_SCANS identical frames.
module matrix_keypad_scanner #(
   parameter int unsigned SCAN_DIV  = 16,
   parameter int unsigned DEB_SCANS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   matrix_keypad_scanner_if.slave  kp
);

   localparam int unsigned CNT_W   = 4;
   localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_SCANS);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
   typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_t;

   logic [3:0]          col_s1;
   logic [3:0]          col_s2;
   logic [SCAN_DIV-1:0] presc;
   logic                tick;
   logic [1:0]          row_idx;
   logic [3:0]          row_q;
   logic [11:0]         acc;

   logic [15:0]         frame_bits;
   logic [4:0]          frame_ones;
   logic [3:0]          frame_key;
   frame_t              frame_kind;
   logic                frame_end;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [3:0]          cand;
   logic [3:0]          code_q;
   logic                valid_q;
   logic                held_q;

   // Two-flop synchroniser for the asynchronous column lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_s1 <= 4'hF;
         col_s2 <= 4'hF;
      end else begin
         col_s1 <= kp.col_n;
         col_s2 <= col_s1;
      end
   end

   assign tick      = &presc;
   assign frame_end = tick && (row_idx == 2'd3);

   // Prescaler, row sequencing and per-row capture of pressed columns
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         row_idx <= 2'd0;
         row_q   <= 4'b1110;
         acc     <= '0;
      end else begin
         presc <= presc + SCAN_DIV'(1);
         if (tick) begin
            row_idx <= row_idx + 2'd1;
            row_q   <= ~(4'b0001 << (row_idx + 2'd1));
            case (row_idx)
               2'd0:    acc[3:0]  <= ~col_s2;
               2'd1:    acc[7:4]  <= ~col_s2;
               2'd2:    acc[11:8] <= ~col_s2;
               default: acc       <= '0;
            endcase
         end
      end
   end

   // Whole-frame view: row 3 is taken live from the synchroniser at frame end
   always_comb begin
      frame_bits = {~col_s2, acc};
      frame_ones = 5'd0;
      frame_key  = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (frame_bits[i]) begin
            frame_ones = frame_ones + 5'd1;
            frame_key  = 4'(i);
         end
      end
      if (frame_ones == 5'd0)      frame_kind = FR_NONE;
      else if (frame_ones == 5'd1) frame_kind = FR_SINGLE;
      else                         frame_kind = FR_MULTI;
   end

   // Debounce FSM; only advances on frame boundaries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         cand    <= 4'd0;
         code_q  <= 4'd0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (frame_end) begin
            case (state)
               IDLE: begin
                  if (frame_kind == FR_SINGLE) begin
                     cand <= frame_key;
                     if (DEB_MAX == CNT_W'(1)) begin
                        code_q  <= frame_key;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        cnt     <= '0;
                        state   <= PRESSED;
                     end else begin
                        cnt   <= CNT_W'(1);
                        state <= DEBOUNCE;
                     end
                  end
               end
               DEBOUNCE: begin
                  if (frame_kind == FR_SINGLE && frame_key == cand) begin
                     if (cnt + CNT_W'(1) >= DEB_MAX) begin
                        code_q  <= cand;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        cnt     <= '0;
                        state   <= PRESSED;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end else if (frame_kind == FR_SINGLE) begin
                     cand <= frame_key;
                     cnt  <= CNT_W'(1);
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end
               PRESSED: begin
                  // Rollover and multi-key frames keep the key held without re-strobing
                  if (frame_kind == FR_NONE) begin
                     if (DEB_MAX == CNT_W'(1)) begin
                        held_q <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                     end else begin
                        cnt   <= CNT_W'(1);
                        state <= RELEASE;
                     end
                  end
               end
               RELEASE: begin
                  if (frame_kind == FR_NONE) begin
                     if (cnt + CNT_W'(1) >= DEB_MAX) begin
                        held_q <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end else begin
                     cnt   <= '0;
                     state <= PRESSED;
                  end
               end
               default: begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign kp.row_n     = row_q;
   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Frame-level bench for matrix_keypad_scanner: a simulated keypad answers the row
// drive, and per-frame expectations are queued and checked at every frame end.
module tb_matrix_keypad_scanner;

   localparam int unsigned SCAN_DIV  = 2;
   localparam int unsigned DEB_SCANS = 3;
   localparam int unsigned FRAME     = 16;

   typedef struct packed {
      logic [15:0] keys;
      logic        valid;
      logic [3:0]  code;
      logic        held;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] keys  = 16'h0000;

   int total = 0;
   int bad   = 0;

   logic [3:0] code_exp = 4'd0;
   logic       held_exp = 1'b0;

   vec_t tbl_a[$];
   vec_t tbl_b[$];
   vec_t sb[$];

   matrix_keypad_scanner_if kp();

   matrix_keypad_scanner #(
      .SCAN_DIV  (SCAN_DIV),
      .DEB_SCANS (DEB_SCANS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp.slave)
   );

   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its column low while its row is driven low
   always_comb begin
      kp.col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!kp.row_n[r]) kp.col_n = kp.col_n & ~keys[r*4 +: 4];
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [15:0] k, input int n, input logic v,
                      input logic [3:0] c, input logic h, input bit to_b);
      vec_t e;
      e = '{keys: k, valid: v, code: c, held: h};
      for (int i = 0; i < n; i++) begin
         if (to_b) tbl_b.push_back(e);
         else      tbl_a.push_back(e);
      end
   endtask

   task automatic run_frame(input vec_t v);
      vec_t       e;
      logic [3:0] row_exp;
      keys = v.keys;
      sb.push_back(v);
      for (int c = 1; c <= int'(FRAME); c++) begin
         @(posedge clk);
         @(negedge clk);
         row_exp = ~(4'b0001 << 2'(c / 4));
         check("row_n", 16'(kp.row_n), 16'(row_exp));
         if (c < int'(FRAME)) begin
            check("valid_mid", 16'(kp.key_valid), 16'(1'b0));
            check("held_mid", 16'(kp.key_held), 16'(held_exp));
            check("code_mid", 16'(kp.key_code), 16'(code_exp));
         end else if (sb.size() == 0) begin
            check("sb_empty", 16'(1), 16'(0));
         end else begin
            e = sb.pop_front();
            check("valid_end", 16'(kp.key_valid), 16'(e.valid));
            check("code_end", 16'(kp.key_code), 16'(e.code));
            check("held_end", 16'(kp.key_held), 16'(e.held));
            code_exp = e.code;
            held_exp = e.held;
         end
      end
   endtask

   initial begin
      // Segment A: idle, clean press, bounce, multi-key, release glitch, rollover, candidate change
      add(16'h0000, 10, 1'b0, 4'd0,  1'b0, 1'b0);
      add(16'h0040, 2,  1'b0, 4'd0,  1'b0, 1'b0);
      add(16'h0040, 1,  1'b1, 4'd6,  1'b1, 1'b0);
      add(16'h0040, 3,  1'b0, 4'd6,  1'b1, 1'b0);
      add(16'h0000, 2,  1'b0, 4'd6,  1'b1, 1'b0);
      add(16'h0000, 2,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h0040, 1,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h0000, 1,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h0040, 2,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h0040, 1,  1'b1, 4'd6,  1'b1, 1'b0);
      add(16'h0040, 1,  1'b0, 4'd6,  1'b1, 1'b0);
      add(16'h0000, 2,  1'b0, 4'd6,  1'b1, 1'b0);
      add(16'h0000, 1,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h0240, 8,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h0030, 2,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h0000, 1,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h8000, 2,  1'b0, 4'd6,  1'b0, 1'b0);
      add(16'h8000, 1,  1'b1, 4'd15, 1'b1, 1'b0);
      add(16'h0000, 1,  1'b0, 4'd15, 1'b1, 1'b0);
      add(16'h8000, 2,  1'b0, 4'd15, 1'b1, 1'b0);
      add(16'h0000, 2,  1'b0, 4'd15, 1'b1, 1'b0);
      add(16'h0000, 1,  1'b0, 4'd15, 1'b0, 1'b0);
      add(16'h0008, 2,  1'b0, 4'd15, 1'b0, 1'b0);
      add(16'h0008, 1,  1'b1, 4'd3,  1'b1, 1'b0);
      add(16'h1008, 3,  1'b0, 4'd3,  1'b1, 1'b0);
      add(16'h1000, 3,  1'b0, 4'd3,  1'b1, 1'b0);
      add(16'h0000, 2,  1'b0, 4'd3,  1'b1, 1'b0);
      add(16'h0000, 1,  1'b0, 4'd3,  1'b0, 1'b0);
      add(16'h0001, 2,  1'b0, 4'd3,  1'b0, 1'b0);
      add(16'h0020, 2,  1'b0, 4'd3,  1'b0, 1'b0);
      add(16'h0020, 1,  1'b1, 4'd5,  1'b1, 1'b0);
      add(16'h0000, 2,  1'b0, 4'd5,  1'b1, 1'b0);
      add(16'h0000, 1,  1'b0, 4'd5,  1'b0, 1'b0);
      // Segment B: after the mid-debounce reset a full fresh qualification is needed
      add(16'h0400, 2,  1'b0, 4'd0,  1'b0, 1'b1);
      add(16'h0400, 1,  1'b1, 4'd10, 1'b1, 1'b1);
      add(16'h0000, 2,  1'b0, 4'd10, 1'b1, 1'b1);
      add(16'h0000, 1,  1'b0, 4'd10, 1'b0, 1'b1);

      #12;
      check("rst_row_n", 16'(kp.row_n), 16'(4'b1110));
      check("rst_code",  16'(kp.key_code), 16'(4'd0));
      check("rst_valid", 16'(kp.key_valid), 16'(1'b0));
      check("rst_held",  16'(kp.key_held), 16'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl_a.size(); i++) run_frame(tbl_a[i]);

      // Two qualifying frames of key 10, then reset mid-way through the third
      run_frame('{keys: 16'h0400, valid: 1'b0, code: 4'd5, held: 1'b0});
      run_frame('{keys: 16'h0400, valid: 1'b0, code: 4'd5, held: 1'b0});
      repeat (6) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_row_n", 16'(kp.row_n), 16'(4'b1110));
      check("arst_code",  16'(kp.key_code), 16'(4'd0));
      check("arst_valid", 16'(kp.key_valid), 16'(1'b0));
      check("arst_held",  16'(kp.key_held), 16'(1'b0));
      code_exp = 4'd0;
      held_exp = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_hold_valid", 16'(kp.key_valid), 16'(1'b0));
         check("rst_hold_row_n", 16'(kp.row_n), 16'(4'b1110));
      end
      rst_n = 1'b1;

      for (int i = 0; i < tbl_b.size(); i++) run_frame(tbl_b[i]);

      check("sb_drained", 16'(sb.size()), 16'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
